eth_tx_framer: RTL and testbench



---
 rtl/eth_tx_framer.sv | 189 ++++++++++++++++++
 tb/tb_eth_tx_framer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_framer.sv
// MII transmit framer for a 10/100 MAC: preamble/SFD, data nibbles low-first,
// zero padding to the minimum length, FCS from the external CRC, then the inter-frame gap.
module eth_tx_framer #(
    parameter int MIN_BYTES   = 60,
    parameter int PRE_NIBBLES = 15,
    parameter int IFG_NIBBLES = 24
) (
    input  logic        clk,
    input  logic        res,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic        crc_ena,
    output logic        crc_shift,
    output logic [3:0]  crc_din,
    input  logic [31:0] crc_fcs,
    output logic [3:0]  txd,
    output logic        tx_en,
    output logic        tx_er,
    output logic        underrun
);

    localparam int MAX_A   = (PRE_NIBBLES > IFG_NIBBLES) ? PRE_NIBBLES : IFG_NIBBLES;
    localparam int MAX_B   = (2 * MIN_BYTES > 8) ? 2 * MIN_BYTES : 8;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(MIN_BYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_DLO, S_DHI, S_PAD, S_FCS, S_IFG
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic [BW-1:0]   r_bytes, w_bytes_next;
    logic [3:0]      r_hi, w_hi_next;
    logic            r_last, w_last_next;
    logic [3:0]      r_txd, w_txd_next;
    logic            r_tx_en, w_tx_en_next;
    logic            r_tx_er, w_tx_er_next;
    logic            r_underrun, w_underrun_next;
    logic [BW-1:0]   w_bytes_inc;
    logic [CW-1:0]   w_pad_nibbles;
    logic            w_fcs_unused;

    // Only the top nibble of the FCS register is ever looked at; the CRC shifts the rest up.
    assign w_fcs_unused = ^crc_fcs[27:0];

    assign w_bytes_inc   = (r_bytes == BW'(MIN_BYTES)) ? r_bytes : r_bytes + 1'b1;
    assign w_pad_nibbles = CW'(2 * (MIN_BYTES - int'(w_bytes_inc)));

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_bytes_next    = r_bytes;
        w_hi_next       = r_hi;
        w_last_next     = r_last;
        w_txd_next      = 4'h0;
        w_tx_en_next    = 1'b0;
        w_tx_er_next    = 1'b0;
        w_underrun_next = 1'b0;
        in_ready        = 1'b0;
        crc_ena         = 1'b0;
        crc_shift       = 1'b0;
        crc_din         = 4'h0;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_next = S_PRE;
                    w_cnt_next   = CW'(PRE_NIBBLES);
                end
            end
            S_PRE: begin
                w_txd_next   = 4'h5;
                w_tx_en_next = 1'b1;
                if (r_cnt <= CW'(1)) begin
                    w_state_next = S_SFD;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_SFD: begin
                w_txd_next   = 4'hD;
                w_tx_en_next = 1'b1;
                w_bytes_next = '0;
                w_state_next = S_DLO;
            end
            S_DLO: begin
                in_ready     = 1'b1;
                w_tx_en_next = 1'b1;
                if (in_valid) begin
                    w_txd_next   = in_data[3:0];
                    crc_ena      = 1'b1;
                    crc_din      = in_data[3:0];
                    w_hi_next    = in_data[7:4];
                    w_last_next  = in_last;
                    w_state_next = S_DHI;
                end else begin
                    // Starved mid-frame: one error nibble, no FCS, straight into the gap.
                    w_tx_er_next    = 1'b1;
                    w_underrun_next = 1'b1;
                    w_state_next    = S_IFG;
                    w_cnt_next      = CW'(IFG_NIBBLES - 1);
                end
            end
            S_DHI: begin
                w_txd_next   = r_hi;
                w_tx_en_next = 1'b1;
                crc_ena      = 1'b1;
                crc_din      = r_hi;
                w_bytes_next = w_bytes_inc;
                if (!r_last) begin
                    w_state_next = S_DLO;
                end else if (w_bytes_inc < BW'(MIN_BYTES)) begin
                    w_state_next = S_PAD;
                    w_cnt_next   = w_pad_nibbles;
                end else begin
                    w_state_next = S_FCS;
                    w_cnt_next   = CW'(8);
                end
            end
            S_PAD: begin
                w_tx_en_next = 1'b1;
                crc_ena      = 1'b1;
                if (r_cnt <= CW'(1)) begin
                    w_state_next = S_FCS;
                    w_cnt_next   = CW'(8);
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_FCS: begin
                w_txd_next   = ~{crc_fcs[28], crc_fcs[29], crc_fcs[30], crc_fcs[31]};
                w_tx_en_next = 1'b1;
                crc_shift    = 1'b1;
                if (r_cnt <= CW'(1)) begin
                    w_state_next = S_IFG;
                    w_cnt_next   = CW'(IFG_NIBBLES - 1);
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_IFG: begin
                // One gap nibble is always contributed by the IDLE cycle that follows.
                if (r_cnt <= CW'(1)) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bytes    <= '0;
            r_hi       <= 4'h0;
            r_last     <= 1'b0;
            r_txd      <= 4'h0;
            r_tx_en    <= 1'b0;
            r_tx_er    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_bytes    <= w_bytes_next;
            r_hi       <= w_hi_next;
            r_last     <= w_last_next;
            r_txd      <= w_txd_next;
            r_tx_en    <= w_tx_en_next;
            r_tx_er    <= w_tx_er_next;
            r_underrun <= w_underrun_next;
        end
    end

    assign txd      = r_txd;
    assign tx_en    = r_tx_en;
    assign tx_er    = r_tx_er;
    assign underrun = r_underrun;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer with a nibble CRC-32 model on the crc_* pins
// and a negedge monitor that captures every tx_en burst.
module tb_eth_tx_framer;

    logic        clk;
    logic        res;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        crc_ena;
    logic        crc_shift;
    logic [3:0]  crc_din;
    logic [31:0] crc_fcs;
    logic [3:0]  txd;
    logic        tx_en;
    logic        tx_er;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    eth_tx_framer dut (
        .clk       (clk),
        .res       (res),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .crc_ena   (crc_ena),
        .crc_shift (crc_shift),
        .crc_din   (crc_din),
        .crc_fcs   (crc_fcs),
        .txd       (txd),
        .tx_en     (tx_en),
        .tx_er     (tx_er),
        .underrun  (underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] crc_fold(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 4; i++) begin
            fb = d[i] ^ r[31];
            r  = {r[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
        end
        return r;
    endfunction

    // External CRC generator model: fold, shift out, or reinitialise.
    always @(posedge clk or posedge res) begin
        if (res)             crc_fcs <= 32'hFFFFFFFF;
        else if (crc_ena)    crc_fcs <= crc_fold(crc_fcs, crc_din);
        else if (crc_shift)  crc_fcs <= {crc_fcs[27:0], 4'hF};
        else                 crc_fcs <= 32'hFFFFFFFF;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Per-frame capture, indexed by frame number.
    logic [3:0]  f_nib   [0:31][0:255];
    int          f_len   [0:31];
    int          f_gap   [0:31];
    int          f_er    [0:31];
    int          f_ur    [0:31];
    int          f_rdy   [0:31];
    int          f_rdy2  [0:31];
    logic        f_laster[0:31];
    logic [31:0] f_res   [0:31];
    int          frames_done;
    int          both_cnt;

    initial begin
        int   cur_len, cur_er, cur_ur, cur_rdy, cur_rdy2, gap_cnt;
        logic prev_en, prev_rdy, cur_lasterr;
        logic [31:0] r;
        frames_done = 0; both_cnt = 0;
        cur_len = 0; cur_er = 0; cur_ur = 0; cur_rdy = 0; cur_rdy2 = 0; gap_cnt = 0;
        prev_en = 1'b0; prev_rdy = 1'b0; cur_lasterr = 1'b0;
        forever begin
            @(negedge clk);
            if (crc_ena && crc_shift) both_cnt++;
            if (tx_en === 1'b1) begin
                if (!prev_en) begin
                    if (frames_done < 32) f_gap[frames_done] = gap_cnt;
                    cur_len = 0; cur_er = 0; cur_ur = 0; cur_rdy = 0; cur_rdy2 = 0;
                end
                if (frames_done < 32 && cur_len < 256) f_nib[frames_done][cur_len] = txd;
                cur_len++;
                if (tx_er) cur_er++;
                if (underrun) cur_ur++;
                if (in_ready) begin
                    cur_rdy++;
                    if (prev_rdy) cur_rdy2++;
                end
                cur_lasterr = tx_er;
            end else begin
                if (prev_en) begin
                    if (frames_done < 32) begin
                        r = 32'hFFFFFFFF;
                        for (int k = 16; k < cur_len && k < 256; k++) r = crc_fold(r, f_nib[frames_done][k]);
                        f_res[frames_done]    = r;
                        f_len[frames_done]    = cur_len;
                        f_er[frames_done]     = cur_er;
                        f_ur[frames_done]     = cur_ur;
                        f_rdy[frames_done]    = cur_rdy;
                        f_rdy2[frames_done]   = cur_rdy2;
                        f_laster[frames_done] = cur_lasterr;
                    end
                    frames_done++;
                    gap_cnt = 1;
                end else begin
                    gap_cnt++;
                end
            end
            prev_en  = (tx_en === 1'b1);
            prev_rdy = (tx_en === 1'b1) && in_ready;
        end
    end

    task automatic send_frame(input int n, input int base, input int step, input bit with_last);
        int idx;
        int guard;
        idx = 0;
        guard = 0;
        while (idx < n && guard < 3000) begin
            @(negedge clk);
            guard++;
            in_data  = 8'(base + idx * step);
            in_valid = 1'b1;
            in_last  = with_last && (idx == n - 1);
            if (in_ready) idx++;
        end
        chk("send_bytes", 32'(idx), 32'(n));
    endtask

    task automatic drop_valid();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int g;
        g = 0;
        while (frames_done < target && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk("frame_seen", 32'(frames_done >= target), 32'd1);
    endtask

    task automatic check_frame(input int fi, input int n, input int base, input int step);
        int m, bad_pre, bad_dat, bad_pad;
        logic [7:0] b;
        m = (n > 60) ? n : 60;
        bad_pre = 0; bad_dat = 0; bad_pad = 0;
        $display("frame %0d: bytes=%0d nibbles=%0d gap=%0d resid=0x%08h", fi, n, f_len[fi], f_gap[fi], f_res[fi]);
        chk("len", 32'(f_len[fi]), 32'(16 + 2 * m + 8));
        for (int k = 0; k < 15; k++) if (f_nib[fi][k] != 4'h5) bad_pre++;
        if (f_nib[fi][15] != 4'hD) bad_pre++;
        chk("preamble_sfd", 32'(bad_pre), 32'd0);
        for (int i = 0; i < n; i++) begin
            b = 8'(base + i * step);
            if (f_nib[fi][16 + 2 * i] != b[3:0]) bad_dat++;
            if (f_nib[fi][17 + 2 * i] != b[7:4]) bad_dat++;
        end
        chk("data", 32'(bad_dat), 32'd0);
        for (int k = 16 + 2 * n; k < 16 + 2 * m; k++) if (f_nib[fi][k] != 4'h0) bad_pad++;
        chk("pad", 32'(bad_pad), 32'd0);
        chk("residue", f_res[fi], 32'hC704DD7B);
        chk("tx_er", 32'(f_er[fi]), 32'd0);
        chk("rdy_count", 32'(f_rdy[fi]), 32'(n));
        chk("rdy_adjacent", 32'(f_rdy2[fi]), 32'd0);
    endtask

    initial begin
        int f0;
        res = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_en", 32'(tx_en), 32'd0);
        chk("rst_txd", 32'(txd), 32'd0);
        chk("rst_tx_er", 32'(tx_er), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_crc_ena", 32'(crc_ena), 32'd0);
        res = 1'b0;
        repeat (3) @(negedge clk);

        // Single byte: maximum padding.
        f0 = frames_done;
        send_frame(1, 8'hA5, 0, 1'b1);
        drop_valid();
        wait_frames(f0 + 1);
        check_frame(f0, 1, 8'hA5, 0);
        chk("one_byte_lo", 32'(f_nib[f0][16]), 32'h5);
        chk("one_byte_hi", 32'(f_nib[f0][17]), 32'hA);
        repeat (30) @(negedge clk);

        // Exactly minimum length: no padding.
        f0 = frames_done;
        send_frame(60, 0, 1, 1'b1);
        drop_valid();
        wait_frames(f0 + 1);
        check_frame(f0, 60, 0, 1);
        repeat (30) @(negedge clk);

        // Above minimum length.
        f0 = frames_done;
        send_frame(100, 8'h10, 3, 1'b1);
        drop_valid();
        wait_frames(f0 + 1);
        check_frame(f0, 100, 8'h10, 3);
        repeat (30) @(negedge clk);

        // Back-to-back with in_valid held high.
        f0 = frames_done;
        send_frame(5, 8'h40, 7, 1'b1);
        send_frame(3, 8'hC0, 1, 1'b1);
        drop_valid();
        wait_frames(f0 + 2);
        check_frame(f0, 5, 8'h40, 7);
        check_frame(f0 + 1, 3, 8'hC0, 1);
        chk("b2b_gap", 32'(f_gap[f0 + 1]), 32'd24);
        repeat (30) @(negedge clk);

        // Starvation at byte 10, next frame offered immediately.
        f0 = frames_done;
        send_frame(10, 8'h20, 1, 1'b0);
        drop_valid();
        @(negedge clk);
        send_frame(4, 8'h50, 5, 1'b1);
        drop_valid();
        wait_frames(f0 + 2);
        $display("frame %0d: underrun nibbles=%0d tx_er=%0d pulses=%0d", f0, f_len[f0], f_er[f0], f_ur[f0]);
        chk("urun_len", 32'(f_len[f0]), 32'd37);
        chk("urun_tx_er", 32'(f_er[f0]), 32'd1);
        chk("urun_last_er", 32'(f_laster[f0]), 32'd1);
        chk("urun_pulse", 32'(f_ur[f0]), 32'd1);
        chk("urun_gap", 32'(f_gap[f0 + 1]), 32'd24);
        check_frame(f0 + 1, 4, 8'h50, 5);
        repeat (30) @(negedge clk);

        // Reset during byte 20, then a new frame with no gap wait.
        f0 = frames_done;
        send_frame(21, 8'h60, 1, 1'b0);
        @(negedge clk);
        #2 res = 1'b1;
        #1;
        chk("async_tx_en", 32'(tx_en), 32'd0);
        chk("async_txd", 32'(txd), 32'd0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        res = 1'b0;
        send_frame(2, 8'h33, 8'h11, 1'b1);
        drop_valid();
        wait_frames(f0 + 2);
        $display("frame %0d: truncated nibbles=%0d", f0, f_len[f0]);
        chk("trunc_len", 32'(f_len[f0]), 32'd57);
        chk("post_reset_gap", 32'(f_gap[f0 + 1]), 32'd4);
        check_frame(f0 + 1, 2, 8'h33, 8'h11);

        chk("ena_and_shift", 32'(both_cnt), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
